// File: rtl/zbc_iter.sv
// zbc_iter -- iterative carry-less multiplier (clmul / clmulh / clmulr)
//
// Retires STEP multiplier bits per cycle into a 2*WIDTH-bit XOR accumulator.
// It uses a Start/Busy/Done handshake so the issuing pipeline can stall on it.
//
// Ports:
//   clk        clock
//   reset_n    synchronous reset, active-low
//   Start      request, accepted when Busy=0 and Flush=0
//   Flush      abort the in-flight operation (also blocks a same-cycle Start)
//   Funct3     001=clmul, 011=clmulh, 010=clmulr, anything else yields 0
//   A, B       multiplicand / multiplier, sampled on accept
//   Busy       high while the multiply is iterating
//   Done       one-cycle pulse, ZBCResult valid
//   ZBCResult  result, held until the next completed operation or reset
//
// Optional feature: define ZBC_EARLYOUT_EN to finish as soon as the
// remaining multiplier bits are all zero (minimum one RUN cycle).

module zbc_iter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic             Flush,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ZBCResult
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LASTCNT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [2*WIDTH-1:0] ashift;
    logic [WIDTH-1:0]   bsh, bsh_rest;
    logic [WIDTH-1:0]   resq, final_res;
    logic [2:0]         f3q;
    logic [CW-1:0]      cnt;
    logic               accept, last_chunk;

    // A request can be taken in IDLE and also in DONE (back-to-back issue).
    assign accept = Start && !Flush && ((state == IDLE) || (state == DONE));

    assign Busy = (state == RUN);
    assign Done = (state == DONE) && !Flush;

    // The result is shown straight from the accumulator during the Done
    // pulse and captured into resq, so a flushed DONE leaves it untouched.
    assign ZBCResult = Done ? final_res : resq;

    // Instead of indexing B and shifting A by counter*STEP, the multiplicand
    // is pre-shifted and the multiplier consumed from the bottom, so each
    // cycle only looks at bsh[STEP-1:0] with fixed shift amounts.
    always_comb begin
        acc_nxt = acc;
        for (int j = 0; j < STEP; j++) begin
            if (bsh[j]) begin
                acc_nxt = acc_nxt ^ (ashift << j);
            end
        end
    end

    assign bsh_rest = bsh >> STEP;

`ifdef ZBC_EARLYOUT_EN
    // Stop once no set multiplier bits remain above this chunk.
    assign last_chunk = (cnt == LASTCNT) || (bsh_rest == '0);
`else
    assign last_chunk = (cnt == LASTCNT);
`endif

    // Select the result window of the 2*WIDTH-bit product.
    always_comb begin
        final_res = '0;
        case (f3q)
            3'b001:  final_res = acc[WIDTH-1:0];
            3'b011:  final_res = acc[2*WIDTH-1:WIDTH];
            3'b010:  final_res = acc[2*WIDTH-2:WIDTH-1];
            default: final_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (Flush) begin
                    state_nxt = IDLE;
                end else if (last_chunk) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = accept ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration and result capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc    <= '0;
            ashift <= '0;
            bsh    <= '0;
            f3q    <= '0;
            cnt    <= '0;
            resq   <= '0;
        end else begin
            if (Done) begin
                resq <= final_res;
            end
            if (accept) begin
                ashift <= {{WIDTH{1'b0}}, A};
                bsh    <= B;
                f3q    <= Funct3;
                acc    <= '0;
                cnt    <= '0;
            end else if ((state == RUN) && !Flush) begin
                acc    <= acc_nxt;
                ashift <= ashift << STEP;
                bsh    <= bsh_rest;
                cnt    <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_zbc_iter.sv
// tb_zbc_iter -- scoreboard bench for zbc_iter (WIDTH=32, STEP=4).
// Stimulus pushes the hand-computed result and absolute Done cycle into a
// queue; a negedge monitor pops and compares whenever Done is seen.

module tb_zbc_iter;

    logic        clk;
    logic        reset_n;
    logic        Start;
    logic        Flush;
    logic [2:0]  Funct3;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] ZBCResult;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    zbc_iter #(.WIDTH(32), .STEP(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Start     (Start),
        .Flush     (Flush),
        .Funct3    (Funct3),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .ZBCResult (ZBCResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc holds the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for a single cycle; if it should complete, queue the
    // expected result and the cycle its Done must appear in.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input bit doPush, input logic [31:0] expRes, input int lat);
        Funct3 = f;
        A      = a;
        B      = b;
        Start  = 1'b1;
        step();
        Start  = 1'b0;
        if (doPush) sb.push_back('{expRes, cyc + lat});
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        checkOutput("drain", 64'(sb.size()), 64'd0);
        step();
    endtask

    // Monitor: every Done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (Done) begin
            checkOutput("busyInDone", 64'(Busy), 64'd0);
            if (sb.size() == 0) begin
                checkOutput("spuriousDone", 64'(Done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("result", 64'(ZBCResult), 64'(e.res));
                checkOutput("doneCycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic runMain();
        int e;
        // Basic clmul and fixed latency.
        applyStimulus(3'b001, 32'h3, 32'h3, 1, 32'h5, 8);
        checkOutput("busyAfterAccept", 64'(Busy), 64'd1);
        waitDrain();
        applyStimulus(3'b011, 32'h80000000, 32'h80000000, 1, 32'h40000000, 8);
        waitDrain();
        applyStimulus(3'b010, 32'h80000000, 32'h80000000, 1, 32'h80000000, 8);
        waitDrain();
        applyStimulus(3'b001, 32'h80000000, 32'h80000000, 1, 32'h00000000, 8);
        waitDrain();
        applyStimulus(3'b011, 32'hFFFFFFFF, 32'h3, 1, 32'h00000001, 8);
        waitDrain();
        applyStimulus(3'b000, 32'h3, 32'h3, 1, 32'h00000000, 8);
        waitDrain();

        // Start while busy is ignored; Start in DONE is accepted.
        applyStimulus(3'b001, 32'h5, 32'h7, 1, 32'h1B, 8);
        e = cyc;
        repeat (2) step();
        Funct3 = 3'b001; A = 32'hAA; B = 32'hBB; Start = 1'b1;
        step();
        Start = 1'b0;
        repeat (5) step();
        checkOutput("doneSeenAtCycle9", 64'(Done), 64'd1);
        applyStimulus(3'b001, 32'hF0, 32'h11, 1, 32'hFF0, 8);
        checkOutput("backToBackCycle", 64'(cyc + 8), 64'(e + 17));
        waitDrain();

        // Flush mid-operation keeps the old result.
        applyStimulus(3'b001, 32'h3, 32'h3, 1, 32'h5, 8);
        waitDrain();
        applyStimulus(3'b001, 32'h5, 32'h7, 0, 32'h0, 8);
        repeat (3) step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        checkOutput("flushBusy", 64'(Busy), 64'd0);
        checkOutput("flushResult", 64'(ZBCResult), 64'h5);
        repeat (12) step();
        checkOutput("flushHold", 64'(ZBCResult), 64'h5);

        // Flush and Start together in IDLE: not accepted.
        Funct3 = 3'b001; A = 32'h3; B = 32'h3; Start = 1'b1; Flush = 1'b1;
        step();
        Start = 1'b0; Flush = 1'b0;
        checkOutput("flushStartBusy", 64'(Busy), 64'd0);
        repeat (12) step();

        // Reset in the middle of an operation.
        applyStimulus(3'b001, 32'h5, 32'h7, 0, 32'h0, 8);
        repeat (4) step();
        reset_n = 1'b0;
        step();
        checkOutput("midResetBusy", 64'(Busy), 64'd0);
        checkOutput("midResetDone", 64'(Done), 64'd0);
        checkOutput("midResetResult", 64'(ZBCResult), 64'd0);
        reset_n = 1'b1;
        step();
        applyStimulus(3'b011, 32'hFFFFFFFF, 32'h3, 1, 32'h00000001, 8);
        waitDrain();
    endtask

    task automatic runEarlyOut();
        applyStimulus(3'b001, 32'hFFFFFFFF, 32'h00000001, 1, 32'hFFFFFFFF, 1);
        waitDrain();
        applyStimulus(3'b001, 32'hFFFFFFFF, 32'h00000010, 1, 32'hFFFFFFF0, 2);
        waitDrain();
        applyStimulus(3'b001, 32'hFFFFFFFF, 32'h80000000, 1, 32'h80000000, 8);
        waitDrain();
        applyStimulus(3'b001, 32'h12345678, 32'h00000000, 1, 32'h00000000, 1);
        waitDrain();
        applyStimulus(3'b011, 32'hFFFFFFFF, 32'h3, 1, 32'h00000001, 1);
        waitDrain();
    endtask

    initial begin
        reset_n = 1'b0;
        Start   = 1'b0;
        Flush   = 1'b0;
        Funct3  = 3'b000;
        A       = '0;
        B       = '0;
        repeat (3) step();
        checkOutput("resetBusy", 64'(Busy), 64'd0);
        checkOutput("resetDone", 64'(Done), 64'd0);
        checkOutput("resetResult", 64'(ZBCResult), 64'd0);
        reset_n = 1'b1;
        step();
`ifdef ZBC_EARLYOUT_EN
        runEarlyOut();
`else
        runMain();
`endif
        checkOutput("pendingOps", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/zbc_iter.md
Name: zbc_iter

Overview:
- Iterative, parametrised Zbc carry-less multiply unit for the bit-manipulation unit (BMU).
- Executes clmul, clmulh and clmulr over WIDTH-bit operands, retiring STEP multiplier bits per cycle.
- Trades latency for area against the single-cycle combinational carry-less multiplier.
- Sits beside the BMU and uses a Start/Busy/Done handshake so the IEU can stall on it.

Parameters:
- WIDTH, 32: operand/result width; 32 or 64.
- STEP, 4: multiplier bits consumed per cycle; must divide WIDTH; 1 to WIDTH.

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous reset, active-low.
- Start  input  1  request; accepted when Start=1 and Busy=0.
- Flush  input  1  abort the in-flight operation.
- Funct3  input  3  001=clmul, 011=clmulh, 010=clmulr; all other codes are invalid.
- A  input  WIDTH  multiplicand, sampled on accept.
- B  input  WIDTH  multiplier, sampled on accept.
- Busy  output  1  high while computing.
- Done  output  1  one-cycle pulse; ZBCResult is valid.
- ZBCResult  output  WIDTH  result, held until the next accept or reset.

Behaviour:
- Reset: while reset_n=0 at a rising edge, state goes to IDLE and Busy=0, Done=0, ZBCResult=0, counter=0, accumulator=0.
- Reset overrides everything, including a mid-operation computation.
- Product definition: P is the 2*WIDTH-bit XOR-sum of (A<<i) over every i with B[i]=1.
- clmul result = P[WIDTH-1:0].
- clmulh result = P[2*WIDTH-1:WIDTH].
- clmulr result = P[2*WIDTH-2:WIDTH-1].
- Invalid Funct3: the operation runs the normal latency and delivers ZBCResult=0 with a Done pulse.
- States and transitions:
  - IDLE -> RUN on accept. Accept latches A, B and Funct3, clears the 2*WIDTH-bit accumulator, and sets counter=0.
  - RUN: each cycle, for j in 0..STEP-1, if Bq[counter*STEP+j]=1 then XOR (Aq << (counter*STEP+j)) into the accumulator; then counter++.
  - RUN -> DONE after the chunk with counter = WIDTH/STEP-1 is processed.
  - DONE: Done=1 and ZBCResult is loaded from the final accumulator per Funct3. Next state is IDLE, or RUN if Start=1 in this cycle (back-to-back accept).
- Latency: accept at edge 0 gives Busy=1 for cycles 1..N with N=WIDTH/STEP, and Done=1 in cycle N+1. Busy=0 in DONE.
- Start while Busy=1 is ignored; no queuing and no error signal.
- Flush=1 in RUN or DONE: next state IDLE, Done suppressed, ZBCResult keeps its previous value.
- Flush and Start in the same cycle: Flush wins and the request is not accepted.
- Flush in IDLE has no effect.
- Counter: width is clog2(WIDTH/STEP), minimum 1 bit. It never wraps during RUN because the terminal count forces DONE.
- ZBCResult changes only in DONE or on reset; it is stable at all other times.
- Datapath: operand pre-reversal is permitted as an implementation choice. Results must match the P definition bit-exactly for every STEP.

Optional Feature:
- Macro: ZBC_EARLYOUT_EN.
- Defined: after each RUN cycle, if all unprocessed multiplier bits Bq[WIDTH-1:(counter+1)*STEP] are zero, go to DONE next. The minimum is one RUN cycle, so B=0 or B=1 gives Done in cycle 2. Results are unchanged.
- Undefined: fixed latency N+1 regardless of operand values.

Test Plan (WIDTH=32, STEP=4, macro undefined unless stated):
- clmul, A=0x00000003, B=0x00000003, accept at cycle 0 -> Busy cycles 1..8, Done=1 only in cycle 9, ZBCResult=0x00000005.
- clmulh A=0x80000000 B=0x80000000 -> 0x40000000. clmulr with the same operands -> 0x80000000. clmul with the same operands -> 0x00000000.
- Accept clmul A=0x5 B=0x7, then Start with other operands at cycle 3 -> the second request is ignored and Done at cycle 9 gives 0x0000001B. Start asserted in the DONE cycle -> the back-to-back op is accepted and its Done arrives in cycle 18.
- Flush at cycle 4 mid-op, with prior ZBCResult=0x5 -> no Done pulse, Busy=0 from cycle 5, ZBCResult stays 0x5. Flush+Start in the same IDLE cycle -> not accepted.
- reset_n=0 at cycle 5 mid-op -> Busy, Done and ZBCResult are 0 at the next cycle. An op accepted after reset completes normally.
- ZBC_EARLYOUT_EN defined:
  - clmul A=0xFFFFFFFF B=0x00000001 -> Done in cycle 2, result 0xFFFFFFFF.
  - B=0x00000010 -> Done in cycle 3, result 0xFFFFFFF0.
  - B=0x80000000 -> Done in cycle 9.
